// File: rtl/ss_pkg.sv
// Shared types and helpers for the stochastic-symbol (SS) arithmetic blocks.
package ss_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } ss_state_e;

    // Symbol width after stochastic rounding of an IW-bit operand with an RW-bit random number.
    function automatic int unsigned ss_symbol_w(input int unsigned iw, input int unsigned rw);
        return iw - rw + 1;
    endfunction

endpackage

// File: rtl/ss_generator_param.sv
// Combinational stochastic rounding: symbol = (operand + randnum) >> RW at IW+1 bits.
module ss_generator_param #(
    parameter int unsigned IW = 9,
    parameter int unsigned RW = 8,
    parameter int unsigned SW = IW - RW + 1
) (
    input  logic [IW-1:0] operand_i,
    input  logic [RW-1:0] randnum_i,
    output logic [SW-1:0] symbol_o
);

    logic [IW:0] sum;

    assign sum      = {1'b0, operand_i} + {{(IW + 1 - RW){1'b0}}, randnum_i};
    assign symbol_o = SW'(sum >> RW);

endmodule

// File: rtl/ss_multiplication_seq.sv
// Sequential SS multiplier: accumulates seq_len stochastic symbol products per start/done frame.
module ss_multiplication_seq
    import ss_pkg::*;
#(
    parameter int unsigned IW    = 9,
    parameter int unsigned RW    = 8,
    parameter int unsigned LEN_W = 10,
    localparam int unsigned SW    = ss_symbol_w(IW, RW),
    localparam int unsigned ACC_W = 2 * SW + LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [LEN_W-1:0] seq_len_i,
    input  logic [IW-1:0]    x_input_i,
    input  logic [IW-1:0]    y_input_i,
    input  logic [RW-1:0]    x_randnum_i,
    input  logic [RW-1:0]    y_randnum_i,
    output logic             sample_en_o,
    output logic             busy_o,
    output logic [ACC_W-1:0] z_output_o,
    output logic             z_valid_o
);

    ss_state_e        state_q;
    logic [ACC_W-1:0] acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [ACC_W-1:0] z_q;
    logic             z_valid_q;

    logic [SW-1:0]    x_ss;
    logic [SW-1:0]    y_ss;
    logic [2*SW-1:0]  prod;

    ss_generator_param #(
        .IW (IW),
        .RW (RW),
        .SW (SW)
    ) u_gen_x (
        .operand_i (x_input_i),
        .randnum_i (x_randnum_i),
        .symbol_o  (x_ss)
    );

    ss_generator_param #(
        .IW (IW),
        .RW (RW),
        .SW (SW)
    ) u_gen_y (
        .operand_i (y_input_i),
        .randnum_i (y_randnum_i),
        .symbol_o  (y_ss)
    );

    // Max product is below 2^(2*SW), so seq_len products cannot overflow ACC_W.
    assign prod = {{SW{1'b0}}, x_ss} * {{SW{1'b0}}, y_ss};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            z_q       <= '0;
            z_valid_q <= 1'b0;
        end else begin
            z_valid_q <= 1'b0;
            if (abort_i) begin
                state_q <= StIdle;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            acc_q <= '0;
                            if (seq_len_i != '0) begin
                                cnt_q   <= seq_len_i;
                                state_q <= StRun;
                            end else begin
                                state_q <= StDone;
                            end
                        end
                    end
                    StRun: begin
                        acc_q <= acc_q + ACC_W'(prod);
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        z_q       <= acc_q;
                        z_valid_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sample_en_o = (state_q == StRun);
    assign busy_o      = (state_q != StIdle);
    assign z_output_o  = z_q;
    assign z_valid_o   = z_valid_q;

endmodule

// File: tb/tb_ss_multiplication_seq.sv
// Directed self-checking bench for ss_multiplication_seq with a small cycle-level model.
module tb_ss_multiplication_seq;

    localparam int unsigned IW    = 9;
    localparam int unsigned RW    = 8;
    localparam int unsigned LEN_W = 10;
    localparam int unsigned ACC_W = 2 * (IW - RW + 1) + LEN_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] seq_len;
    logic [IW-1:0]    x_input;
    logic [IW-1:0]    y_input;
    logic [RW-1:0]    x_randnum;
    logic [RW-1:0]    y_randnum;
    logic             sample_en;
    logic             busy;
    logic [ACC_W-1:0] z_output;
    logic             z_valid;

    int n_checks;
    int n_fail;
    int last_z;

    ss_multiplication_seq #(
        .IW    (IW),
        .RW    (RW),
        .LEN_W (LEN_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .seq_len_i   (seq_len),
        .x_input_i   (x_input),
        .y_input_i   (y_input),
        .x_randnum_i (x_randnum),
        .y_randnum_i (y_randnum),
        .sample_en_o (sample_en),
        .busy_o      (busy),
        .z_output_o  (z_output),
        .z_valid_o   (z_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sym(input int op, input int r);
        return (op + r) >> RW;
    endfunction

    // Runs one sequence; poke >= 0 pulses start at that post-edge index to test it is ignored.
    task automatic run_seq(input string tag, input int len, input int x, input int y,
                           input bit xrnd, input int xr, input int yr, input int poke);
        int  acc;
        int  se_cnt;
        bit  got;
        x_input   = IW'(x);
        y_input   = IW'(y);
        x_randnum = RW'(xr);
        y_randnum = RW'(yr);
        @(negedge clk);
        start   = 1'b1;
        seq_len = LEN_W'(len);
        @(posedge clk);
        #1 start = 1'b0;
        acc    = 0;
        se_cnt = 0;
        got    = 1'b0;
        for (int k = 0; k < len + 20 && !got; k++) begin
            @(negedge clk);
            if (z_valid) begin
                check({tag, "_latency"}, k, len + 1);
                got = 1'b1;
            end else begin
                if (sample_en) se_cnt++;
                start = (k == poke);
                if (k == poke) seq_len = LEN_W'(2);
                if (xrnd) x_randnum = RW'($urandom_range(0, 255));
                if (k < len) acc += sym(x, int'(x_randnum)) * sym(y, int'(y_randnum));
            end
        end
        start = 1'b0;
        if (!got) check({tag, "_timeout"}, 0, 1);
        check({tag, "_sample_cnt"}, se_cnt, len);
        check({tag, "_z"}, z_output, acc);
        @(negedge clk);
        check({tag, "_pulse_one"}, z_valid, 0);
        check({tag, "_hold"}, z_output, acc);
        check({tag, "_idle"}, busy, 0);
        last_z = acc;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_z    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        seq_len   = '0;
        x_input   = '0;
        y_input   = '0;
        x_randnum = '0;
        y_randnum = '0;
        #1;
        check("rst_z", z_output, 0);
        check("rst_valid", z_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sample", sample_en, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Symbols 1*1 per cycle.
        run_seq("basic", 4, 256, 256, 1'b0, 0, 0, -1);
        check("basic_val", last_z, 4);

        // Max operands and randoms: symbols 2*2 over the longest sequence.
        run_seq("max", 1023, 511, 511, 1'b0, 255, 255, -1);
        check("max_val", last_z, 4092);
        run_seq("zero_x", 5, 0, 511, 1'b0, 255, 255, -1);
        check("zero_x_val", last_z, 0);

        // 1.5 * 1.0 with uniform X randoms.
        run_seq("rand", 1000, 384, 256, 1'b1, 0, 0, -1);
        check("rand_range", (last_z >= 1440 && last_z <= 1560), 1);

        run_seq("len0", 0, 511, 511, 1'b0, 255, 255, -1);

        // Start pulsed during RUN must not restart or shorten the sequence.
        run_seq("start_busy", 6, 256, 256, 1'b0, 0, 0, 2);
        check("start_busy_val", last_z, 6);

        run_seq("pre_abort", 7, 256, 256, 1'b0, 0, 0, -1);
        @(negedge clk);
        start   = 1'b1;
        seq_len = LEN_W'(10);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sample", sample_en, 0);
        check("abort_valid", z_valid, 0);
        check("abort_z", z_output, 7);
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(negedge clk);
                if (z_valid) seen++;
            end
            check("abort_no_result", seen, 0);
        end
        run_seq("post_abort", 3, 256, 256, 1'b0, 0, 0, -1);

        // Abort landing in DONE suppresses that result.
        @(negedge clk);
        start   = 1'b1;
        seq_len = '0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_valid", z_valid, 0);
        check("abort_done_z", z_output, 3);
        check("abort_done_busy", busy, 0);

        // Asynchronous reset between edges mid-RUN.
        x_input   = IW'(511);
        y_input   = IW'(511);
        x_randnum = RW'(255);
        y_randnum = RW'(255);
        @(negedge clk);
        start   = 1'b1;
        seq_len = LEN_W'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_z", z_output, 0);
        check("arst_valid", z_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_sample", sample_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("post_rst", 2, 256, 256, 1'b0, 0, 0, -1);
        check("post_rst_val", last_z, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
